// File: rtl/qspi_write_seq.sv
// rtl/qspi_write_seq.sv - QSPI flash page-write sequencer (WREN/SE/PP with RDSR polling)
module qspi_write_seq #(
  parameter int POLL_MAX = 4096,
  parameter int ERASE_EN = 1
) (
  input  logic          CLK_100M,
  input  logic          RESET_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_erase,
  input  logic          req_quad,
  input  logic [23:0]   req_addr,
  input  logic [2047:0] req_data,
  output logic          done,
  output logic          fail,
  output logic [1:0]    fail_code,
  output logic          trigger,
  output logic          quad,
  output logic [7:0]    cmd,
  output logic [23:0]   addr,
  output logic [2047:0] data_send,
  input  logic [7:0]    readout,
  input  logic          busy,
  input  logic          error
);

  localparam int CW = $clog2(POLL_MAX + 1);

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;

  // Steps run in ascending order; erase-less requests start at STEP_WREN_PP.
  localparam logic [1:0] STEP_WREN_SE = 2'd0;
  localparam logic [1:0] STEP_SE      = 2'd1;
  localparam logic [1:0] STEP_WREN_PP = 2'd2;
  localparam logic [1:0] STEP_PP      = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT,
    S_POLL_ISSUE, S_POLL_SETTLE, S_POLL_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [CW-1:0] poll_q, poll_d;
  logic [CW-1:0] poll_inc;
  logic [1:0]    code_q, code_d;
  logic          quad_q, quad_d;
  logic [23:0]   addr_q, addr_d;
  logic [2047:0] data_q;
  logic [7:0]    step_op;
  logic [23:0]   step_addr;
  logic          step_is_write;
  logic          unused_readout;

  // Only the WIP bit of the status register matters here.
  assign unused_readout = ^readout[7:1];

  assign step_is_write = step_q[0];
  assign step_op   = !step_q[0] ? OP_WREN : (step_q[1] ? OP_PP : OP_SE);
  assign step_addr = !step_q[0] ? 24'h0 :
                     (step_q[1] ? addr_q : {addr_q[23:16], 16'h0});

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fail      = (state_q == S_DONE) && (code_q != 2'd0);
  assign fail_code = code_q;
  assign quad      = quad_q;
  assign data_send = data_q;
  assign poll_inc  = poll_q + CW'(1);

  // Next-state and controller-facing command outputs.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    poll_d  = poll_q;
    code_d  = code_q;
    quad_d  = quad_q;
    addr_d  = addr_q;
    trigger = 1'b0;
    cmd     = 8'h00;
    addr    = 24'h0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          quad_d = req_quad;
          addr_d = req_addr;
          step_d = (req_erase && (ERASE_EN != 0)) ? STEP_WREN_SE : STEP_WREN_PP;
          if (req_addr[7:0] != 8'h00) begin
            code_d  = 2'd3;
            state_d = S_DONE;
          end else begin
            code_d  = 2'd0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cmd  = step_op;
        addr = step_addr;
        if (!busy) begin
          trigger = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cmd     = step_op;
        addr    = step_addr;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cmd  = step_op;
        addr = step_addr;
        if (!busy) begin
          if (error) begin
            code_d  = 2'd1;
            state_d = S_DONE;
          end else if (step_is_write) begin
            poll_d  = '0;
            state_d = S_POLL_ISSUE;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_POLL_ISSUE: begin
        cmd = OP_RDSR;
        if (!busy) begin
          trigger = 1'b1;
          state_d = S_POLL_SETTLE;
        end
      end
      S_POLL_SETTLE: begin
        cmd     = OP_RDSR;
        state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        cmd = OP_RDSR;
        if (!busy) begin
          if (error) begin
            code_d  = 2'd1;
            state_d = S_DONE;
          end else if (!readout[0]) begin
            if (step_q == STEP_SE) begin
              step_d  = STEP_WREN_PP;
              state_d = S_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            poll_d = poll_inc;
            if (poll_inc == CW'(POLL_MAX)) begin
              code_d  = 2'd2;
              state_d = S_DONE;
            end else begin
              state_d = S_POLL_ISSUE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge CLK_100M) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      step_q  <= STEP_WREN_SE;
      poll_q  <= '0;
      code_q  <= 2'd0;
      quad_q  <= 1'b0;
      addr_q  <= 24'h0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      poll_q  <= poll_d;
      code_q  <= code_d;
      quad_q  <= quad_d;
      addr_q  <= addr_d;
    end
  end

  // Page payload is captured on acceptance and deliberately survives reset.
  always_ff @(posedge CLK_100M) begin
    if (RESET_N && (state_q == S_IDLE) && req_valid) begin
      data_q <= req_data;
    end
  end

endmodule
